// File: rtl/irq_pkg.sv
// rtl/irq_pkg.sv - shared state encoding, register offsets and defaults for irq_controller
package irq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } irq_state_e;

  localparam logic [1:0] MASK_OFS = 2'd0;
  localparam logic [1:0] PEND_OFS = 2'd1;
  localparam logic [1:0] INSV_OFS = 2'd2;
  localparam logic [1:0] EOI_OFS  = 2'd3;

  localparam logic [15:0] SPURIOUS_VEC_DEF = 16'h0008;

  function automatic logic [15:0] zext8(input logic [7:0] v);
    return {8'h00, v};
  endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// rtl/irq_sync_edge.sv - per-bit two-flop synchronizer followed by a rising-edge pulse
module irq_sync_edge #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] i_async,
  output logic [W-1:0] o_rise
);

  logic [W-1:0] r_s1;
  logic [W-1:0] r_s2;
  logic [W-1:0] r_s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= '0;
      r_s2 <= '0;
      r_s3 <= '0;
    end else begin
      r_s1 <= i_async;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  // one-cycle pulse, so a level-held line contributes only once
  assign o_rise = r_s2 & ~r_s3;

endmodule

// File: rtl/irq_controller.sv
// rtl/irq_controller.sv - single-level priority interrupt controller with memory-mapped mask/pending/EOI
module irq_controller
  import irq_pkg::*;
#(
  parameter int          N_SRC        = 8,
  parameter logic [11:0] BASE_ADDR    = 12'hFF0,
  parameter logic [15:0] SPURIOUS_VEC = SPURIOUS_VEC_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_SRC-1:0] irq_src,
  input  logic [11:0]      address,
  input  logic [15:0]      data_out,
  input  logic             memwt,
  output logic             INT,
  input  logic             intack,
  output logic [15:0]      rd_data,
  output logic             rd_sel
);

  irq_state_e       r_state;
  irq_state_e       w_state_nxt;
  logic             r_int;
  logic [N_SRC-1:0] r_mask;
  logic [N_SRC-1:0] r_pend;
  logic [N_SRC-1:0] r_insv;

  logic [N_SRC-1:0] w_rise;
  logic [N_SRC-1:0] w_elig;
  logic [N_SRC-1:0] w_win_oh;
  logic [2:0]       w_win_idx;
  logic             w_any;
  logic [N_SRC-1:0] w_pend_clr;
  logic [N_SRC-1:0] w_pend_nxt;
  logic [N_SRC-1:0] w_insv_nxt;
  logic [11:0]      w_ofs_full;
  logic [1:0]       w_ofs;
  logic             w_in_range;
  logic             w_wr_mask;
  logic             w_wr_pend;
  logic             w_wr_eoi;
  logic             w_ack_take;
  logic [15:0]      w_vec;
  logic             w_unused_data;

  irq_sync_edge #(
    .W(N_SRC)
  ) u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_async(irq_src),
    .o_rise (w_rise)
  );

  assign w_ofs_full = address - BASE_ADDR;
  assign w_in_range = (w_ofs_full < 12'd4);
  assign w_ofs      = w_ofs_full[1:0];

  assign w_wr_mask = memwt & w_in_range & (w_ofs == MASK_OFS);
  assign w_wr_pend = memwt & w_in_range & (w_ofs == PEND_OFS);
  assign w_wr_eoi  = memwt & w_in_range & (w_ofs == EOI_OFS);

  assign w_unused_data = ^data_out[15:N_SRC];

  assign w_elig = r_pend & r_mask;
  assign w_any  = |w_elig;

  // scan from the top so the lowest set index is the last one written
  always_comb begin
    w_win_idx = '0;
    w_win_oh  = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (w_elig[i]) begin
        w_win_idx   = 3'(i);
        w_win_oh    = '0;
        w_win_oh[i] = 1'b1;
      end
    end
  end

  assign w_ack_take = intack & (r_state == REQ) & w_any;

  assign w_pend_clr = (w_wr_pend ? data_out[N_SRC-1:0] : '0)
                    | (w_ack_take ? w_win_oh : '0);
  // new edges are OR-ed in after the clear so a coincident set wins
  assign w_pend_nxt = (r_pend & ~w_pend_clr) | w_rise;
  assign w_insv_nxt = (w_wr_eoi ? '0 : r_insv) | (w_ack_take ? w_win_oh : '0);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_any && (r_insv == '0)) w_state_nxt = REQ;
      end
      REQ: begin
        if (!w_any)      w_state_nxt = IDLE;
        else if (intack) w_state_nxt = SERVICE;
      end
      SERVICE: begin
        if (w_wr_eoi) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_int   <= 1'b0;
      r_mask  <= '0;
      r_pend  <= '0;
      r_insv  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_int   <= (w_state_nxt == REQ);
      if (w_wr_mask) r_mask <= data_out[N_SRC-1:0];
      r_pend  <= w_pend_nxt;
      r_insv  <= w_insv_nxt;
    end
  end

  assign INT = r_int;

  assign w_vec = w_any ? {13'd0, w_win_idx} : SPURIOUS_VEC;

  // the acknowledge cycle owns the data bus regardless of address
  always_comb begin
    rd_sel  = 1'b0;
    rd_data = '0;
    if (intack) begin
      rd_sel  = 1'b1;
      rd_data = w_vec;
    end else if (w_in_range && !memwt) begin
      rd_sel = 1'b1;
      case (w_ofs)
        MASK_OFS: rd_data = zext8(8'(r_mask));
        PEND_OFS: rd_data = zext8(8'(r_pend));
        INSV_OFS: rd_data = zext8(8'(r_insv));
        default:  rd_data = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_controller.sv
// tb/tb_irq_controller.sv - directed scoreboard bench for irq_controller
module tb_irq_controller;

  localparam logic [11:0] BASE = 12'hFF0;

  logic        clk;
  logic        rst_n;
  logic [7:0]  irq_src;
  logic [11:0] address;
  logic [15:0] data_out;
  logic        memwt;
  logic        int_o;
  logic        intack;
  logic [15:0] rd_data;
  logic        rd_sel;

  logic        exp_rd;
  logic        probe_int;
  logic        done_req;
  logic        final_done;

  logic [15:0] rd_val_q[$];
  string       rd_name_q[$];
  logic        int_val_q[$];
  string       int_name_q[$];

  int          n_chk;
  int          n_fail;
  logic [15:0] ev;
  logic        ei;
  string       nm;

  irq_controller #(
    .N_SRC       (8),
    .BASE_ADDR   (12'hFF0),
    .SPURIOUS_VEC(16'h0008)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .irq_src (irq_src),
    .address (address),
    .data_out(data_out),
    .memwt   (memwt),
    .INT     (int_o),
    .intack  (intack),
    .rd_data (rd_data),
    .rd_sel  (rd_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // monitor: samples on the falling edge, away from the active edge
  initial begin
    n_chk      = 0;
    n_fail     = 0;
    final_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rd_sel || exp_rd) begin
        n_chk++;
        if (rd_val_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_rd_sel: rd_sel=%b rd_data=%h, required no read", rd_sel, rd_data);
        end else begin
          ev = rd_val_q.pop_front();
          nm = rd_name_q.pop_front();
          if (rd_sel !== 1'b1 || rd_data !== ev) begin
            n_fail++;
            $display("FAIL %s: rd_sel=%b rd_data=%h, required rd_sel=1 rd_data=%h", nm, rd_sel, rd_data, ev);
          end
        end
      end
      if (probe_int) begin
        n_chk++;
        if (int_val_q.size() == 0) begin
          n_fail++;
          $display("FAIL int_probe_empty: INT=%b with no expectation", int_o);
        end else begin
          ei = int_val_q.pop_front();
          nm = int_name_q.pop_front();
          if (int_o !== ei) begin
            n_fail++;
            $display("FAIL %s: INT=%b, required %b", nm, int_o, ei);
          end
        end
      end
      if (done_req && !final_done) begin
        final_done = 1'b1;
        n_chk++;
        if (rd_val_q.size() != 0 || int_val_q.size() != 0) begin
          n_fail++;
          $display("FAIL leftover_expectations: %0d read and %0d INT left, required 0",
                   rd_val_q.size(), int_val_q.size());
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    address   = '0;
    data_out  = '0;
    memwt     = 1'b0;
    intack    = 1'b0;
    exp_rd    = 1'b0;
    probe_int = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic sb_rd(input logic [15:0] v, input string name);
    rd_val_q.push_back(v);
    rd_name_q.push_back(name);
    exp_rd = 1'b1;
  endtask

  task automatic sb_int(input logic v, input string name);
    int_val_q.push_back(v);
    int_name_q.push_back(name);
    probe_int = 1'b1;
  endtask

  task automatic wr_reg(input logic [1:0] ofs, input logic [15:0] d);
    address  = BASE + 12'(ofs);
    data_out = d;
    memwt    = 1'b1;
    step();
  endtask

  task automatic rd_reg(input logic [1:0] ofs, input logic [15:0] v, input string name);
    address = BASE + 12'(ofs);
    sb_rd(v, name);
    step();
  endtask

  task automatic ack(input logic [15:0] v, input string name);
    intack = 1'b1;
    sb_rd(v, name);
    step();
  endtask

  task automatic chk_int(input logic v, input string name);
    sb_int(v, name);
    step();
  endtask

  initial begin
    rst_n     = 1'b0;
    irq_src   = '0;
    address   = '0;
    data_out  = '0;
    memwt     = 1'b0;
    intack    = 1'b0;
    exp_rd    = 1'b0;
    probe_int = 1'b0;
    done_req  = 1'b0;
    @(posedge clk);
    #1;

    // reset state
    sb_int(1'b0, "reset_int");
    address = BASE;
    sb_rd(16'h0000, "reset_mask");
    step();
    rd_reg(2'd1, 16'h0000, "reset_pend");
    rd_reg(2'd2, 16'h0000, "reset_insv");
    rst_n = 1'b1;
    step();

    // single source, edge-to-INT latency
    wr_reg(2'd0, 16'h0004);
    irq_src = 8'h04;
    chk_int(1'b0, "t1_int_c1");
    chk_int(1'b0, "t1_int_c2");
    irq_src = 8'h00;
    chk_int(1'b0, "t1_int_c3");
    rd_reg(2'd1, 16'h0004, "t1_pend");
    chk_int(1'b1, "t1_int_c5");
    ack(16'h0002, "t1_vector");
    rd_reg(2'd2, 16'h0004, "t1_insv");
    rd_reg(2'd1, 16'h0000, "t1_pend_after_ack");
    chk_int(1'b0, "t1_int_service");

    // priority, no nesting, EOI re-request
    wr_reg(2'd3, 16'h0000);
    wr_reg(2'd0, 16'h00FF);
    irq_src = 8'h22;
    idle(4);
    chk_int(1'b1, "t2_int_req");
    irq_src = 8'h00;
    ack(16'h0001, "t2_vector1");
    rd_reg(2'd1, 16'h0020, "t2_pend");
    chk_int(1'b0, "t2_int_service_a");
    chk_int(1'b0, "t2_int_service_b");
    wr_reg(2'd3, 16'h0000);
    chk_int(1'b0, "t2_int_after_eoi");
    chk_int(1'b1, "t2_int_reassert");
    ack(16'h0005, "t2_vector2");
    rd_reg(2'd2, 16'h0020, "t2_insv");
    wr_reg(2'd3, 16'h0000);
    wr_reg(2'd0, 16'h0000);

    // mask-gated request withdrawn before acknowledge
    irq_src = 8'h08;
    idle(2);
    irq_src = 8'h00;
    idle(2);
    rd_reg(2'd1, 16'h0008, "t3_pend");
    chk_int(1'b0, "t3_int_masked");
    wr_reg(2'd0, 16'h0008);
    chk_int(1'b0, "t3_int_idle");
    chk_int(1'b1, "t3_int_req");
    wr_reg(2'd0, 16'h0000);
    chk_int(1'b1, "t3_int_still_req");
    chk_int(1'b0, "t3_int_dropped");
    rd_reg(2'd1, 16'h0008, "t3_pend_kept");
    wr_reg(2'd1, 16'h0008);
    rd_reg(2'd1, 16'h0000, "t3_pend_w1c");

    // W1C coinciding with a fresh edge, then level hold
    irq_src = 8'h10;
    idle(2);
    wr_reg(2'd1, 16'h0010);
    rd_reg(2'd1, 16'h0010, "t4_set_wins");
    idle(1);
    wr_reg(2'd1, 16'h0010);
    idle(2);
    rd_reg(2'd1, 16'h0000, "t4_level_once");
    irq_src = 8'h00;

    // spurious acknowledge
    ack(16'h0008, "t5_spurious");
    rd_reg(2'd2, 16'h0000, "t5_insv");
    chk_int(1'b0, "t5_int");

    // asynchronous reset while in service
    wr_reg(2'd0, 16'h0003);
    irq_src = 8'h03;
    idle(4);
    chk_int(1'b1, "t6_int_req");
    ack(16'h0000, "t6_vector");
    irq_src = 8'h00;
    idle(1);
    irq_src = 8'h01;
    idle(3);
    rd_reg(2'd1, 16'h0003, "t6_pend");
    rd_reg(2'd2, 16'h0001, "t6_insv");
    chk_int(1'b0, "t6_int_service");
    irq_src = 8'h00;
    rst_n   = 1'b0;
    sb_int(1'b0, "t6_rst_int");
    address = BASE + 12'd1;
    sb_rd(16'h0000, "t6_rst_pend");
    step();
    rd_reg(2'd0, 16'h0000, "t6_rst_mask");
    rd_reg(2'd2, 16'h0000, "t6_rst_insv");
    rst_n = 1'b1;
    chk_int(1'b0, "t6_int_after_rst");
    rd_reg(2'd1, 16'h0000, "t6_pend_after_rst");

    done_req = 1'b1;
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
- Priority interrupt controller between up to 8 peripheral interrupt lines and the CPU's single INT/intack pair.
- Detects rising edges, latches them as pending, and applies a software mask.
- Raises INT to the CPU. In the CPU's intack cycle it supplies the vector index the CPU adds to 0x7F0 to fetch the ISR address.
- Memory-mapped on the CPU's 12-bit address bus for mask, pending and end-of-interrupt (EOI) control.

Parameters:
- N_SRC, 8, number of interrupt sources (1..8); source 0 is highest priority.
- BASE_ADDR, 12'hFF0, word address of register 0. Registers occupy BASE_ADDR..BASE_ADDR+3.
- SPURIOUS_VEC, 16'h0008, vector returned when intack arrives with nothing eligible.

Ports:
- clk, in, 1, system clock, rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- irq_src, in, N_SRC, raw asynchronous interrupt lines, active high.
- address, in, 12, CPU address bus.
- data_out, in, 16, CPU write data.
- memwt, in, 1, CPU write strobe for the current cycle.
- INT, out, 1, interrupt request to the CPU.
- intack, in, 1, CPU acknowledge; high for exactly one cycle.
- rd_data, out, 16, register read data, or vector data while intack is high.
- rd_sel, out, 1, high when rd_data must replace memory data on the CPU data_in mux.

Behaviour:
- Reset (rst_n low, asynchronous):
  - mask=0, pending=0, in_service=0, synchronizers=0.
  - State=IDLE, INT=0, rd_sel=0, rd_data=0.
- Input conditioning:
  - Each irq_src bit passes through a 2-flop synchronizer, then a rising-edge detector (third flop).
  - An edge sets pending[i] 3 cycles after the input rises.
  - Level-held lines set pending only once per rising edge.
- Register map (word offset from BASE_ADDR):
  - 0, MASK: read/write. Bit i=1 enables source i. Bits 15..N_SRC read 0, writes ignored.
  - 1, PENDING: read; write-1-to-clear.
  - 2, INSERVICE: read only; writes ignored.
  - 3, EOI: write clears in_service entirely (single-level, so at most one bit set). Reads return 0.
- Register access:
  - Writes take effect on the clock edge where memwt=1 and the address matches.
  - Reads are combinational: rd_sel=1 and rd_data=register whenever the address is in range and memwt=0.
- Eligibility:
  - eligible = pending & mask.
  - Winner = lowest set index of eligible, computed combinationally.
- State machine:
  - IDLE: if |eligible and in_service==0, go to REQ.
  - REQ: INT=1.
    - On intack, latch the winner into in_service (set that bit), clear that pending bit, and go to SERVICE.
    - If eligible becomes 0 before intack (mask write or W1C), drop INT and return to IDLE.
  - SERVICE: INT=0. On EOI write, go to IDLE.
  - INT is a registered output: high exactly in REQ.
- Intack cycle:
  - rd_sel=1 and rd_data = {zero-extended winner index} regardless of address.
  - If no source is eligible (spurious ack), rd_data=SPURIOUS_VEC and state is unchanged.
  - The vector is taken from eligible in that same cycle, so a higher-priority edge arriving up to the ack cycle wins.
- Simultaneous events:
  - An edge and a clear (W1C or ack) on the same bit in the same cycle: set wins, pending stays 1.
  - A MASK write and intack in the same cycle: the vector uses the old mask.
  - EOI and a new eligible source in the same cycle: the next cycle goes IDLE, and REQ follows one cycle later.
  - EOI in IDLE/REQ: harmless, clears in_service.
- No nesting: while SERVICE, further edges only accumulate as pending.
- Reset mid-sequence (REQ or SERVICE): return to IDLE, all pending lost.

Decomposition:
- Package irq_pkg holds:
  - State enum (IDLE, REQ, SERVICE).
  - Register offset constants (MASK_OFS=0, PEND_OFS=1, INSV_OFS=2, EOI_OFS=3).
  - SPURIOUS_VEC default.
- One sub-module, irq_sync_edge: per-bit 2-flop synchronizer plus rising-edge pulse, instantiated N_SRC wide.
- Priority encoder stays inline.

Test Plan:
- Reset, write MASK=0x0004, pulse irq_src[2] -> PENDING reads 0x0004. INT rises 4 cycles after the edge. Intack returns rd_data=0x0002. INSERVICE reads 0x0004, PENDING reads 0.
- MASK=0x00FF, raise irq_src[5] and irq_src[1] in the same cycle -> intack vector 0x0001, PENDING=0x0020. INT stays low until an EOI write, then reasserts 2 cycles later. Second intack gives 0x0005.
- Pending source 3 with mask 0, then write MASK=0x0008 -> INT asserts. Write MASK=0 before intack -> INT drops the next cycle and state returns to IDLE.
- Write PENDING=0x0010 in the same cycle as a fresh edge on irq_src[4] -> PENDING still reads 0x0010.
- Intack with nothing eligible -> rd_data=0x0008, rd_sel=1, INSERVICE unchanged at 0.
- Assert rst_n low while in SERVICE with PENDING=0x0003 -> INT=0, all registers read 0 immediately, without waiting for a clock edge.
